// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared state type, PC-select encodings and defaults
package mem_access_unit_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/mem_access_unit_mem_wb.sv
// mem_wb_reg: MEM/WB pipeline register with bubble insertion
//   clk, rst (async active-low)
//   bubble   : clears RegWrite/MemtoReg on this edge
//   rdata_en : captures rdata into mem_read_data_out
//   *_in     : EX/MEM values, *_out : MEM/WB values
module mem_wb_reg
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        rdata_en,
  input  logic        RegWrite_in,
  input  logic [1:0]  MemtoReg_in,
  input  logic [31:0] rdata,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] PC_plus_4_in,
  input  logic [4:0]  rd_in,
  output logic        RegWrite_out,
  output logic [1:0]  MemtoReg_out,
  output logic [31:0] mem_read_data_out,
  output logic [31:0] ALU_result_out,
  output logic [31:0] PC_plus_4_out,
  output logic [4:0]  MEM_WB_RegisterRd_out
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      RegWrite_out          <= 1'b0;
      MemtoReg_out          <= 2'b00;
      mem_read_data_out     <= '0;
      ALU_result_out        <= '0;
      PC_plus_4_out         <= '0;
      MEM_WB_RegisterRd_out <= '0;
    end else begin
      RegWrite_out          <= RegWrite_in & ~bubble;
      MemtoReg_out          <= bubble ? 2'b00 : MemtoReg_in;
      ALU_result_out        <= ALU_result_in;
      PC_plus_4_out         <= PC_plus_4_in;
      MEM_WB_RegisterRd_out <= rd_in;
      if (rdata_en) mem_read_data_out <= rdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage with handshaked data-memory access and PC redirect
//   clk, rst (async active-low)
//   EX/MEM inputs   : control bits, MemtoReg_in, addresses/data, EX_MEM_RegisterRd_in
//   dmem_*          : request (req/we/addr/wdata) and response (ack/rdata)
//   mem_stall       : holds IF/ID/EX and EX/MEM while an access is outstanding
//   PCSrc/PC_target : combinational next-PC select, *_Flush on any redirect
//   align_err/bus_err : one-cycle error pulses
//   MEM/WB outputs  : registered writeback values
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Jump_in,
  input  logic        ALU_zero_in,
  input  logic [1:0]  MemtoReg_in,
  input  logic [31:0] jump_addr_in,
  input  logic [31:0] branch_addr_in,
  input  logic [31:0] PC_plus_4_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] reg_read_data_2_in,
  input  logic [4:0]  EX_MEM_RegisterRd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [1:0]  PCSrc,
  output logic [31:0] PC_target,
  output logic        IF_Flush,
  output logic        ID_Flush,
  output logic        EX_Flush,
  output logic        align_err,
  output logic        bus_err,
  output logic        RegWrite_out,
  output logic [1:0]  MemtoReg_out,
  output logic [31:0] mem_read_data_out,
  output logic [31:0] ALU_result_out,
  output logic [31:0] PC_plus_4_out,
  output logic [4:0]  MEM_WB_RegisterRd_out
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic access, aligned, start, ack_hit, timeout, bubble;
  always_comb begin
    access    = MemRead_in | MemWrite_in;
    aligned   = ALU_result_in[1:0] == 2'b00;
    start     = state == IDLE && access && aligned;
    ack_hit   = state == WAIT && dmem_ack;
    timeout   = state == WAIT && !dmem_ack && cnt == CW'(TIMEOUT - 1);
    mem_stall = start || (state == WAIT && !dmem_ack && !timeout);
    // gated by rst so the pulse is held low while reset is asserted
    align_err = rst && state == IDLE && access && !aligned;
    bus_err   = timeout;
    dmem_req  = state == WAIT;
    bubble    = mem_stall | align_err | timeout;
    PCSrc     = Jump_in ? PC_JUMP : (Branch_in && ALU_zero_in) ? PC_BRANCH : PC_SEQ;
    PC_target = Jump_in ? jump_addr_in : (Branch_in && ALU_zero_in) ? branch_addr_in : PC_plus_4_in;
    IF_Flush  = PCSrc != PC_SEQ;
    ID_Flush  = PCSrc != PC_SEQ;
    EX_Flush  = PCSrc != PC_SEQ;
  end
  // request fields are captured once at issue and held for the whole WAIT
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (start) begin
      state      <= WAIT;
      cnt        <= '0;
      dmem_we    <= MemWrite_in;
      dmem_addr  <= ALU_result_in;
      dmem_wdata <= reg_read_data_2_in;
    end else if (ack_hit || timeout) begin
      state <= IDLE;
    end else if (state == WAIT) begin
      cnt <= cnt + CW'(1);
    end
  mem_wb_reg u_mem_wb (
    .clk                   (clk),
    .rst                   (rst),
    .bubble                (bubble),
    .rdata_en              (ack_hit),
    .RegWrite_in           (RegWrite_in),
    .MemtoReg_in           (MemtoReg_in),
    .rdata                 (dmem_rdata),
    .ALU_result_in         (ALU_result_in),
    .PC_plus_4_in          (PC_plus_4_in),
    .rd_in                 (EX_MEM_RegisterRd_in),
    .RegWrite_out          (RegWrite_out),
    .MemtoReg_out          (MemtoReg_out),
    .mem_read_data_out     (mem_read_data_out),
    .ALU_result_out        (ALU_result_out),
    .PC_plus_4_out         (PC_plus_4_out),
    .MEM_WB_RegisterRd_out (MEM_WB_RegisterRd_out)
  );
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table-driven bench for mem_access_unit
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWrite_in, Branch_in, MemRead_in, MemWrite_in, Jump_in, ALU_zero_in;
  logic [1:0]  MemtoReg_in;
  logic [31:0] jump_addr_in, branch_addr_in, PC_plus_4_in, ALU_result_in, reg_read_data_2_in;
  logic [4:0]  EX_MEM_RegisterRd_in;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, PC_target;
  logic [1:0]  PCSrc, MemtoReg_out;
  logic        IF_Flush, ID_Flush, EX_Flush, align_err, bus_err, RegWrite_out;
  logic [31:0] mem_read_data_out, ALU_result_out, PC_plus_4_out;
  logic [4:0]  MEM_WB_RegisterRd_out;
  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .Branch_in(Branch_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .Jump_in(Jump_in), .ALU_zero_in(ALU_zero_in),
    .MemtoReg_in(MemtoReg_in), .jump_addr_in(jump_addr_in), .branch_addr_in(branch_addr_in),
    .PC_plus_4_in(PC_plus_4_in), .ALU_result_in(ALU_result_in),
    .reg_read_data_2_in(reg_read_data_2_in), .EX_MEM_RegisterRd_in(EX_MEM_RegisterRd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .PCSrc(PCSrc), .PC_target(PC_target),
    .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .EX_Flush(EX_Flush),
    .align_err(align_err), .bus_err(bus_err),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .mem_read_data_out(mem_read_data_out), .ALU_result_out(ALU_result_out),
    .PC_plus_4_out(PC_plus_4_out), .MEM_WB_RegisterRd_out(MEM_WB_RegisterRd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        j, b, z;
    logic [1:0]  pcsrc;
    logic [31:0] target;
    logic [2:0]  flush;
  } pc_vec_t;

  typedef struct {
    logic        rw;
    logic [1:0]  mtr;
    logic [31:0] alu, pc4;
    logic [4:0]  rd;
  } wb_vec_t;

  pc_vec_t pcv [7];
  wb_vec_t wbv [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear;
    {RegWrite_in, Branch_in, MemRead_in, MemWrite_in, Jump_in, ALU_zero_in} = '0;
    MemtoReg_in = 2'b00;
    jump_addr_in = 32'h1000;
    branch_addr_in = 32'h2000;
    PC_plus_4_in = 32'h3004;
    ALU_result_in = '0;
    reg_read_data_2_in = '0;
    EX_MEM_RegisterRd_in = '0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
  endtask

  initial begin
    pcv = '{
      '{1'b0, 1'b0, 1'b0, 2'b00, 32'h3004, 3'b000},
      '{1'b0, 1'b1, 1'b0, 2'b00, 32'h3004, 3'b000},
      '{1'b0, 1'b1, 1'b1, 2'b01, 32'h2000, 3'b111},
      '{1'b0, 1'b0, 1'b1, 2'b00, 32'h3004, 3'b000},
      '{1'b1, 1'b0, 1'b0, 2'b10, 32'h1000, 3'b111},
      '{1'b1, 1'b1, 1'b1, 2'b10, 32'h1000, 3'b111},
      '{1'b1, 1'b1, 1'b0, 2'b10, 32'h1000, 3'b111}
    };
    wbv = '{
      '{1'b1, 2'b10, 32'hA5A5_0001, 32'h0000_0104, 5'd7},
      '{1'b0, 2'b01, 32'h1234_5678, 32'h0000_0208, 5'd31},
      '{1'b1, 2'b11, 32'hFFFF_FFFC, 32'h8000_0000, 5'd1}
    };
    clear();
    #1 rst = 1'b0;
    #2;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_align", 32'(align_err), 0);
    chk("rst_bus", 32'(bus_err), 0);
    chk("rst_rw", 32'(RegWrite_out), 0);
    chk("rst_mtr", 32'(MemtoReg_out), 0);
    chk("rst_rdata", mem_read_data_out, 0);
    chk("rst_alu", ALU_result_out, 0);
    chk("rst_pc4", PC_plus_4_out, 0);
    chk("rst_rd", 32'(MEM_WB_RegisterRd_out), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      Jump_in = pcv[i].j;
      Branch_in = pcv[i].b;
      ALU_zero_in = pcv[i].z;
      #1;
      chk($sformatf("pcsrc[%0d]", i), 32'(PCSrc), 32'(pcv[i].pcsrc));
      chk($sformatf("target[%0d]", i), PC_target, pcv[i].target);
      chk($sformatf("flush[%0d]", i), 32'({IF_Flush, ID_Flush, EX_Flush}), 32'(pcv[i].flush));
    end
    clear();

    for (int i = 0; i < 3; i++) begin
      RegWrite_in = wbv[i].rw;
      MemtoReg_in = wbv[i].mtr;
      ALU_result_in = wbv[i].alu;
      PC_plus_4_in = wbv[i].pc4;
      EX_MEM_RegisterRd_in = wbv[i].rd;
      #1;
      chk($sformatf("pass_stall[%0d]", i), 32'(mem_stall), 0);
      tick();
      chk($sformatf("pass_rw[%0d]", i), 32'(RegWrite_out), 32'(wbv[i].rw));
      chk($sformatf("pass_mtr[%0d]", i), 32'(MemtoReg_out), 32'(wbv[i].mtr));
      chk($sformatf("pass_alu[%0d]", i), ALU_result_out, wbv[i].alu);
      chk($sformatf("pass_pc4[%0d]", i), PC_plus_4_out, wbv[i].pc4);
      chk($sformatf("pass_rd[%0d]", i), 32'(MEM_WB_RegisterRd_out), 32'(wbv[i].rd));
    end

    clear();
    MemRead_in = 1'b1;
    ALU_result_in = 32'h100;
    RegWrite_in = 1'b1;
    MemtoReg_in = 2'b01;
    EX_MEM_RegisterRd_in = 5'd5;
    #1;
    chk("ld_stall0", 32'(mem_stall), 1);
    chk("ld_req0", 32'(dmem_req), 0);
    tick();
    chk("ld_req1", 32'(dmem_req), 1);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_we", 32'(dmem_we), 0);
    chk("ld_stall1", 32'(mem_stall), 1);
    chk("ld_bub1", 32'(RegWrite_out), 0);
    tick();
    chk("ld_stall2", 32'(mem_stall), 1);
    chk("ld_bub2", 32'(RegWrite_out), 0);
    chk("ld_addr2", dmem_addr, 32'h100);
    tick();
    chk("ld_bub3", 32'(RegWrite_out), 0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_stall3", 32'(mem_stall), 0);
    tick();
    chk("ld_rdata", mem_read_data_out, 32'hDEAD_BEEF);
    chk("ld_rw", 32'(RegWrite_out), 1);
    chk("ld_mtr", 32'(MemtoReg_out), 1);
    chk("ld_rd", 32'(MEM_WB_RegisterRd_out), 5);
    chk("ld_req_end", 32'(dmem_req), 0);
    clear();

    MemRead_in = 1'b1;
    MemWrite_in = 1'b1;
    ALU_result_in = 32'h20;
    reg_read_data_2_in = 32'h55;
    #1;
    chk("st_stall0", 32'(mem_stall), 1);
    tick();
    chk("st_req", 32'(dmem_req), 1);
    chk("st_we", 32'(dmem_we), 1);
    chk("st_addr", dmem_addr, 32'h20);
    chk("st_wdata", dmem_wdata, 32'h55);
    dmem_ack = 1'b1;
    #1;
    chk("st_stall1", 32'(mem_stall), 0);
    tick();
    chk("st_req_end", 32'(dmem_req), 0);
    clear();

    MemRead_in = 1'b1;
    ALU_result_in = 32'h40;
    RegWrite_in = 1'b1;
    tick();
    chk("to_bus1", 32'(bus_err), 0);
    chk("to_stall1", 32'(mem_stall), 1);
    tick();
    tick();
    chk("to_bus3", 32'(bus_err), 0);
    tick();
    chk("to_bus4", 32'(bus_err), 1);
    chk("to_stall4", 32'(mem_stall), 0);
    chk("to_req4", 32'(dmem_req), 1);
    tick();
    chk("to_bus_end", 32'(bus_err), 0);
    chk("to_req_end", 32'(dmem_req), 0);
    chk("to_rw", 32'(RegWrite_out), 0);
    clear();

    RegWrite_in = 1'b1;
    tick();
    chk("ma_pre_rw", 32'(RegWrite_out), 1);
    MemRead_in = 1'b1;
    ALU_result_in = 32'h102;
    #1;
    chk("ma_err", 32'(align_err), 1);
    chk("ma_stall", 32'(mem_stall), 0);
    chk("ma_req0", 32'(dmem_req), 0);
    tick();
    chk("ma_req1", 32'(dmem_req), 0);
    chk("ma_rw", 32'(RegWrite_out), 0);
    clear();
    #1;
    chk("ma_err_end", 32'(align_err), 0);

    dmem_ack = 1'b1;
    tick();
    chk("idle_ack_req", 32'(dmem_req), 0);
    chk("idle_ack_stall", 32'(mem_stall), 0);
    clear();

    MemRead_in = 1'b1;
    ALU_result_in = 32'h200;
    tick();
    chk("rs_req", 32'(dmem_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("rs_req_async", 32'(dmem_req), 0);
    chk("rs_bus", 32'(bus_err), 0);
    chk("rs_addr", dmem_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rs_stall", 32'(mem_stall), 1);
    tick();
    chk("rs_req2", 32'(dmem_req), 1);
    chk("rs_addr2", dmem_addr, 32'h200);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    tick();
    chk("rs_rdata", mem_read_data_out, 32'hCAFE_F00D);
    chk("rs_req_end", 32'(dmem_req), 0);
    clear();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, the maximum number of cycles to wait for dmem_ack.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have inputs RegWrite_in, Branch_in, MemRead_in, MemWrite_in, Jump_in and ALU_zero_in, 1 bit each: the EX/MEM control signals.
REQ-005 The block SHALL have input MemtoReg_in, 2 bits: the EX/MEM writeback select.
REQ-006 The block SHALL have inputs jump_addr_in, branch_addr_in, PC_plus_4_in, ALU_result_in and reg_read_data_2_in, 32 bits each: the EX/MEM data.
REQ-007 The block SHALL have input EX_MEM_RegisterRd_in, 5 bits: the destination register.
REQ-008 The block SHALL have outputs dmem_req and dmem_we (1 bit each), and dmem_addr and dmem_wdata (32 bits each): the data-memory request.
REQ-009 The block SHALL have inputs dmem_ack (1 bit) and dmem_rdata (32 bits): the data-memory response.
REQ-010 The block SHALL have output mem_stall, 1 bit: holds IF/ID/EX and EX/MEM.
REQ-011 The block SHALL have outputs PCSrc (2 bits: 00 sequential, 01 branch, 10 jump) and PC_target (32 bits).
REQ-012 The block SHALL have outputs IF_Flush, ID_Flush and EX_Flush, 1 bit each: the redirect flushes.
REQ-013 The block SHALL have outputs align_err and bus_err, 1 bit each: single-cycle error pulses.
REQ-014 The block SHALL have MEM/WB outputs RegWrite_out (1), MemtoReg_out (2), mem_read_data_out (32), ALU_result_out (32), PC_plus_4_out (32) and MEM_WB_RegisterRd_out (5).

Function
REQ-015 A memory access SHALL be requested when MemRead_in or MemWrite_in is 1; if both are 1 the access SHALL be treated as a write.
REQ-016 The state machine SHALL have states IDLE and WAIT.
REQ-017 In IDLE with an aligned access (ALU_result_in[1:0]==00), the block SHALL assert mem_stall combinationally, register dmem_addr=ALU_result_in, dmem_wdata=reg_read_data_2_in and dmem_we=MemWrite_in, and go to WAIT.
REQ-018 dmem_req SHALL equal (state==WAIT); dmem_addr, dmem_we and dmem_wdata SHALL stay stable throughout WAIT.
REQ-019 In WAIT, mem_stall SHALL be 1 while dmem_ack is 0 and 0 in the cycle in which dmem_ack is 1.
REQ-020 On an ack edge the block SHALL load MEM/WB from the inputs, load mem_read_data_out=dmem_rdata, and return to IDLE.
REQ-021 The minimum access latency SHALL be 2 cycles (ack in the first WAIT cycle).
REQ-022 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack.
REQ-023 When the counter reaches TIMEOUT-1 with no ack, the block SHALL pulse bus_err for 1 cycle, release mem_stall, drop dmem_req next cycle, load a MEM/WB bubble and return to IDLE.
REQ-024 A misaligned access (ALU_result_in[1:0]!=00) SHALL issue no request and no stall, SHALL pulse align_err, and SHALL load a bubble.
REQ-025 A bubble SHALL be RegWrite_out=0 and MemtoReg_out=00, with the data fields don't-care.
REQ-026 Every rising edge with mem_stall=1 SHALL load a bubble into MEM/WB.
REQ-027 Every edge with no access and no stall SHALL pass all inputs into MEM/WB unchanged.
REQ-028 PCSrc and PC_target SHALL be combinational: Jump_in selects 10 with jump_addr_in; otherwise Branch_in&ALU_zero_in selects 01 with branch_addr_in; otherwise 00 with PC_plus_4_in.
REQ-029 IF_Flush, ID_Flush and EX_Flush SHALL equal (PCSrc!=00).
REQ-030 Jump SHALL have priority over branch when both are asserted.
REQ-031 An ack arriving in IDLE SHALL be ignored.

Reset
REQ-032 When rst=0, state SHALL be IDLE, the counter 0, and dmem_req, dmem_we, dmem_addr, dmem_wdata, align_err, bus_err and all MEM/WB outputs 0, all immediately and asynchronously.
REQ-033 Reset asserted during WAIT SHALL abandon the access with no error pulse.
REQ-034 After reset release, the first access SHALL start from IDLE.

Structure
REQ-035 A shared package SHALL hold the state enum, the PCSrc encodings (PC_SEQ, PC_BRANCH, PC_JUMP) and the TIMEOUT default.
REQ-036 The MEM/WB register with a bubble input SHALL be a sub-module named mem_wb_reg; the FSM, counter and PC select SHALL stay in mem_access_unit.

Verification
REQ-037 The bench SHALL cover a load: MemRead_in=1, ALU_result_in=0x100, ack on the 3rd WAIT cycle with rdata=0xDEADBEEF -> mem_stall high 3 cycles, one bubble per stalled edge, then mem_read_data_out=0xDEADBEEF.
REQ-038 The bench SHALL cover a store: MemWrite_in=1, addr 0x20, data 0x55, ack immediately -> dmem_we=1, dmem_addr=0x20, dmem_wdata=0x55, stall for 1 cycle.
REQ-039 The bench SHALL cover a timeout: no ack with TIMEOUT=4 -> bus_err pulses on the 4th WAIT cycle, then dmem_req=0 and RegWrite_out=0.
REQ-040 The bench SHALL cover misalignment: MemRead_in=1, ALU_result_in=0x102 -> align_err 1 cycle, dmem_req never 1, no stall.
REQ-041 The bench SHALL cover redirects: Branch_in=1 with ALU_zero_in=0 -> PCSrc=00; with ALU_zero_in=1 -> PCSrc=01, PC_target=branch_addr_in and all flushes 1; Jump_in=1 and Branch_in=1 together -> PCSrc=10.
REQ-042 The bench SHALL cover reset mid-access: rst=0 during WAIT -> dmem_req drops without waiting for a clock edge, no bus_err, and the next access proceeds normally.
